// File: rtl/cpu_run_sequencer.sv
// CPU start-up sequencer: hold core in reset, preload register file with indices, run, drain, done.
// Optional writeback trace FIFO enabled by defining CPU_RUN_SEQ_TRACE_EN.
`timescale 1ns/1ps
module cpu_run_sequencer #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned REG_COUNT    = 32,
  parameter int unsigned ADDR_WIDTH   = 5,
  parameter int unsigned RESET_CYCLES = 1,
  parameter int unsigned RUN_CYCLES   = 20,
  parameter int unsigned DRAIN_CYCLES = 6,
  parameter int unsigned TRACE_DEPTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  output logic                  cpu_rst_n,
  output logic                  rf_we,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  input  logic                  wb_valid,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           cycle_count,
  output logic [15:0]           wb_count,
  input  logic                  trace_rd,
  output logic                  trace_valid,
  output logic [ADDR_WIDTH-1:0] trace_addr,
  output logic [DATA_WIDTH-1:0] trace_data,
  output logic                  trace_overflow
);

  localparam int unsigned PAD = DATA_WIDTH - ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_PRELOAD,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t      state, state_n;
  logic [31:0] cnt, cnt_n;
  logic        launch;
  logic        wb_hit;

  assign wb_hit = (state == S_RUN) && wb_valid && (wb_addr != '0);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    launch  = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_n = S_HOLD;
          cnt_n   = '0;
          launch  = 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt == RESET_CYCLES - 1) begin
          state_n = S_PRELOAD;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 32'd1;
        end
      end
      S_PRELOAD: begin
        if (cnt == REG_COUNT - 1) begin
          state_n = S_RUN;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 32'd1;
        end
      end
      S_RUN: begin
        if (cnt == RUN_CYCLES - 1) begin
          state_n = S_DRAIN;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 32'd1;
        end
      end
      S_DRAIN: begin
        if (cnt == DRAIN_CYCLES - 1) begin
          state_n = S_DONE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 32'd1;
        end
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      cpu_rst_n   <= 1'b0;
      rf_we       <= 1'b0;
      rf_waddr    <= '0;
      rf_wdata    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cycle_count <= '0;
      wb_count    <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      cpu_rst_n <= (state_n == S_RUN);
      rf_we     <= (state_n == S_PRELOAD);
      rf_waddr  <= (state_n == S_PRELOAD) ? cnt_n[ADDR_WIDTH-1:0] : '0;
      rf_wdata  <= (state_n == S_PRELOAD) ? {{PAD{1'b0}}, cnt_n[ADDR_WIDTH-1:0]} : '0;
      busy      <= (state_n != S_IDLE) && (state_n != S_DONE);
      done      <= (state_n == S_DONE);
      if (launch) begin
        cycle_count <= '0;
        wb_count    <= '0;
      end else begin
        if (state == S_RUN) begin
          cycle_count <= cycle_count + 32'd1;
        end
        if (wb_hit && (wb_count != '1)) begin
          wb_count <= wb_count + 16'd1;
        end
      end
    end
  end

`ifdef CPU_RUN_SEQ_TRACE_EN
  localparam int unsigned TW = $clog2(TRACE_DEPTH);

  logic [ADDR_WIDTH+DATA_WIDTH-1:0] mem [TRACE_DEPTH];
  logic [TW:0] wr_ptr, rd_ptr;
  logic        fifo_empty, fifo_full, pop, push;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[TW] != rd_ptr[TW]) && (wr_ptr[TW-1:0] == rd_ptr[TW-1:0]);
  assign pop        = trace_rd && !fifo_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is accepted then.
  assign push       = wb_hit && (!fifo_full || pop);

  always_ff @(posedge clock) begin
    if (reset || launch) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      trace_overflow <= 1'b0;
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (wb_hit && fifo_full && !pop) begin
        trace_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr[TW-1:0]] <= {wb_addr, wb_data};
    end
  end

  assign trace_valid = !fifo_empty;
  assign {trace_addr, trace_data} = fifo_empty ? '0 : mem[rd_ptr[TW-1:0]];
`else
  logic unused_trace;

  assign unused_trace   = ^{trace_rd, wb_data, TRACE_DEPTH};
  assign trace_valid    = 1'b0;
  assign trace_addr     = '0;
  assign trace_data     = '0;
  assign trace_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_run_sequencer.sv
// Self-checking bench for cpu_run_sequencer: per-cycle stimulus tables with a scoreboard queue,
// plus hand-written reset-abort and trace FIFO sequences.
`timescale 1ns/1ps
module tb_cpu_run_sequencer;

  localparam int unsigned DW    = 32;
  localparam int unsigned NREG  = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned NRST  = 1;
  localparam int unsigned NRUN  = 20;
  localparam int unsigned NDRN  = 6;
  localparam int unsigned TD    = 4;
  localparam int unsigned LEN   = NRST + NREG + NRUN + NDRN + 3;
  localparam int unsigned RUN0  = NRST + NREG;

  logic          clock = 1'b0;
  logic          reset, start, wb_valid, trace_rd;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          cpu_rst_n, rf_we, busy, done, trace_valid, trace_overflow;
  logic [AW-1:0] rf_waddr, trace_addr;
  logic [DW-1:0] rf_wdata, trace_data;
  logic [31:0]   cycle_count;
  logic [15:0]   wb_count;

  cpu_run_sequencer #(
    .DATA_WIDTH(DW), .REG_COUNT(NREG), .ADDR_WIDTH(AW), .RESET_CYCLES(NRST),
    .RUN_CYCLES(NRUN), .DRAIN_CYCLES(NDRN), .TRACE_DEPTH(TD)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .cpu_rst_n(cpu_rst_n), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .busy(busy), .done(done), .cycle_count(cycle_count), .wb_count(wb_count),
    .trace_rd(trace_rd), .trace_valid(trace_valid), .trace_addr(trace_addr),
    .trace_data(trace_data), .trace_overflow(trace_overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic          start;
    logic          wb_valid;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          trace_rd;
    logic [15:0]   wbc_next;
  } stim_t;

  typedef struct {
    logic          rst_n;
    logic          we;
    logic [AW-1:0] waddr;
    logic          busy;
    logic          done;
    logic [31:0]   cc;
    logic [15:0]   wbc;
  } exp_t;

  stim_t         tbl [3][LEN];
  exp_t          sb[$];
  logic [DW-1:0] rf_model [NREG];
  int unsigned   n_chk = 0;
  int unsigned   n_fail = 0;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input int unsigned idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: actual=%0h expected=%0h", nm, idx, act, exp);
    end
  endtask

  // 0 HOLD, 1 PRELOAD, 2 RUN, 3 DRAIN, 4 DONE; j counts cycles after the start edge
  function automatic int unsigned phase(input int unsigned j);
    if (j < NRST) return 0;
    if (j < RUN0) return 1;
    if (j < RUN0 + NRUN) return 2;
    if (j < RUN0 + NRUN + NDRN) return 3;
    return 4;
  endfunction

  function automatic exp_t expect_at(input int unsigned j, input logic [15:0] wbc);
    exp_t e;
    int unsigned ph;
    ph      = phase(j);
    e.rst_n = (ph == 2);
    e.we    = (ph == 1);
    e.waddr = (ph == 1) ? AW'(j - NRST) : '0;
    e.busy  = (ph != 4);
    e.done  = (ph == 4);
    e.cc    = (ph == 2) ? (j - RUN0) : ((ph > 2) ? NRUN : 32'd0);
    e.wbc   = wbc;
    return e;
  endfunction

  task automatic run_seq(input int unsigned t);
    stim_t s;
    exp_t  e;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_trace_valid", t, trace_valid, 1'b0);
    chk("restart_overflow", t, trace_overflow, 1'b0);
    sb.push_back(expect_at(0, 16'd0));
    for (int unsigned j = 0; j <= LEN; j++) begin
      if (j < LEN) begin
        s        = tbl[t][j];
        start    = s.start;
        wb_valid = s.wb_valid;
        wb_addr  = s.wb_addr;
        wb_data  = s.wb_data;
        trace_rd = s.trace_rd;
      end
      if (sb.size() == 0) begin
        chk("scoreboard_empty", j, 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("cpu_rst_n", j, cpu_rst_n, e.rst_n);
        chk("rf_we", j, rf_we, e.we);
        chk("rf_waddr", j, rf_waddr, e.waddr);
        chk("rf_wdata", j, rf_wdata, {27'd0, e.waddr});
        chk("busy", j, busy, e.busy);
        chk("done", j, done, e.done);
        chk("cycle_count", j, cycle_count, e.cc);
        chk("wb_count", j, wb_count, e.wbc);
      end
`ifndef CPU_RUN_SEQ_TRACE_EN
      chk("tied_trace", j, {trace_valid, trace_overflow, trace_addr, trace_data[7:0]}, 32'd0);
`endif
      if (rf_we) rf_model[rf_waddr] = rf_wdata;
      if (j == RUN0) begin
        for (int unsigned i = 0; i < NREG; i++) chk("rf_at_run", i, rf_model[i], i);
      end
      if (j < LEN) sb.push_back(expect_at(j + 1, s.wbc_next));
      step();
    end
    start = 1'b0; wb_valid = 1'b0; wb_addr = '0; wb_data = '0; trace_rd = 1'b0;
  endtask

  task automatic pop_check(input logic [AW-1:0] a);
    chk("pop_valid", a, trace_valid, 1'b1);
    chk("pop_addr", a, trace_addr, a);
    chk("pop_data", a, trace_data, 32'hA000_0000 | a);
    trace_rd = 1'b1;
    step();
    trace_rd = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] cnt;
    int          p;
    bit          found;

    for (int unsigned t = 0; t < 3; t++) begin
      cnt = '0;
      for (int unsigned j = 0; j < LEN; j++) begin
        tbl[t][j] = '{start: 1'b0, wb_valid: 1'b0, wb_addr: '0, wb_data: '0,
                      trace_rd: 1'b0, wbc_next: '0};
        p = int'(j) - int'(RUN0);
        if (phase(j) == 2) begin
          if (t == 0) begin
            tbl[t][j].wb_valid = 1'b1;
            tbl[t][j].wb_addr  = (p % 2 == 0) ? 5'd0 : 5'd7;
            tbl[t][j].start    = (p == 5);
          end else if (p < ((t == 1) ? 6 : 5)) begin
            tbl[t][j].wb_valid = 1'b1;
            tbl[t][j].wb_addr  = AW'(p + 1);
            tbl[t][j].trace_rd = (t == 2) && (p == 4);
          end
        end else if (t == 0 && phase(j) >= 3) begin
          tbl[t][j].wb_valid = 1'b1;
          tbl[t][j].wb_addr  = 5'd7;
        end
        tbl[t][j].wb_data = 32'hA000_0000 | tbl[t][j].wb_addr;
        if (phase(j) == 2 && tbl[t][j].wb_valid && tbl[t][j].wb_addr != 0) cnt++;
        tbl[t][j].wbc_next = cnt;
      end
    end
    for (int unsigned i = 0; i < NREG; i++) rf_model[i] = '1;

    reset = 1'b1; start = 1'b0; wb_valid = 1'b0; wb_addr = '0; wb_data = '0; trace_rd = 1'b0;
    step();
    step();
    reset = 1'b0;
    chk("rst_cpu_rst_n", 0, cpu_rst_n, 1'b0);
    chk("rst_rf_we", 0, rf_we, 1'b0);
    chk("rst_rf_waddr", 0, rf_waddr, '0);
    chk("rst_rf_wdata", 0, rf_wdata, '0);
    chk("rst_busy", 0, busy, 1'b0);
    chk("rst_done", 0, done, 1'b0);
    chk("rst_cycle_count", 0, cycle_count, '0);
    chk("rst_wb_count", 0, wb_count, '0);
    chk("rst_trace_valid", 0, trace_valid, 1'b0);
    chk("rst_overflow", 0, trace_overflow, 1'b0);

    // Full sequence: alternating writebacks, ignored mid-RUN start, writebacks after RUN
    run_seq(0);

    // Restart from DONE then reset while preloading index 9
    start = 1'b1;
    step();
    start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (rf_we && rf_waddr == 5'd9) begin
        found = 1'b1;
        break;
      end
      step();
    end
    chk("reach_preload_9", 0, found, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    wb_valid = 1'b1; wb_addr = 5'd3;
    for (int unsigned k = 0; k < 4; k++) begin
      chk("abort_rf_we", k, rf_we, 1'b0);
      chk("abort_cpu_rst_n", k, cpu_rst_n, 1'b0);
      chk("abort_busy", k, busy, 1'b0);
      chk("abort_done", k, done, 1'b0);
      chk("abort_cycle_count", k, cycle_count, '0);
      chk("abort_wb_count", k, wb_count, '0);
      step();
    end
    wb_valid = 1'b0; wb_addr = '0;

`ifdef CPU_RUN_SEQ_TRACE_EN
    run_seq(1);
    chk("t5_overflow", 0, trace_overflow, 1'b1);
    for (int unsigned a = 1; a <= 4; a++) pop_check(AW'(a));
    chk("t5_empty", 0, trace_valid, 1'b0);
    trace_rd = 1'b1;
    step();
    trace_rd = 1'b0;
    chk("t5_pop_empty_ignored", 0, trace_valid, 1'b0);
    chk("t5_overflow_sticky", 0, trace_overflow, 1'b1);

    run_seq(2);
    chk("t6_overflow", 0, trace_overflow, 1'b0);
    for (int unsigned a = 2; a <= 5; a++) pop_check(AW'(a));
    chk("t6_empty", 0, trace_valid, 1'b0);
`else
    trace_rd = 1'b1;
    for (int unsigned k = 0; k < 3; k++) begin
      step();
      chk("tied_valid", k, trace_valid, 1'b0);
      chk("tied_head", k, {trace_addr, trace_data[26:0]}, 32'd0);
      chk("tied_overflow", k, trace_overflow, 1'b0);
    end
    trace_rd = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
